timestamp_timer_mc: RTL and testbench

Parametrised successor to the free-running clock-cycle timer. It provides a timestamp counter with a run-time prescaler, an enable and a synchronous clear. It flags wrap-around and keeps a saturating epoch (wrap) count. N independent capture channels latch the timestamp on request and hold it under a valid/ack handshake. It sits beside the DVS event path, which uses it to stamp incoming events at a selectable time resolution.

---
 rtl/timestamp_timer_mc.sv | 88 ++++++++
 tb/tb_timestamp_timer_mc.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_timer_mc.sv
// rtl/timestamp_timer_mc.sv - prescaled timestamp counter with epoch count and capture channels
// Capture channels sample the registered (pre-increment) timestamp seen in the request cycle.
module timestamp_timer_mc #(
  parameter int TS_BITS       = 32,
  parameter int PRESCALE_BITS = 16,
  parameter int EPOCH_BITS    = 8,
  parameter int NUM_CAPT      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         clear,
  input  logic [PRESCALE_BITS-1:0]     prescale_div,
  output logic [TS_BITS-1:0]           timestamp,
  output logic                         tick,
  output logic                         wrap,
  output logic [EPOCH_BITS-1:0]        epoch,
  input  logic [NUM_CAPT-1:0]          capt_req,
  input  logic [NUM_CAPT-1:0]          capt_ack,
  output logic [NUM_CAPT-1:0]          capt_valid,
  output logic [NUM_CAPT*TS_BITS-1:0]  capt_ts,
  output logic [NUM_CAPT-1:0]          capt_ovf
);

  localparam logic [TS_BITS-1:0]       TS_ONE  = 1;
  localparam logic [PRESCALE_BITS-1:0] PRE_ONE = 1;
  localparam logic [EPOCH_BITS-1:0]    EP_ONE  = 1;

  logic [PRESCALE_BITS-1:0]          pre_cnt;
  logic [NUM_CAPT-1:0][TS_BITS-1:0]  capt_q;

  assign capt_ts = capt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt   <= '0;
      timestamp <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
      epoch     <= '0;
    end else if (clear) begin
      pre_cnt   <= '0;
      timestamp <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
      epoch     <= '0;
    end else if (enable) begin
      // >= so a divisor lowered below the running count restarts on the next enabled cycle
      if (pre_cnt >= prescale_div) begin
        pre_cnt   <= '0;
        timestamp <= timestamp + TS_ONE;
        tick      <= 1'b1;
        wrap      <= (timestamp == '1);
        if (timestamp == '1 && epoch != '1)
          epoch <= epoch + EP_ONE;
      end else begin
        pre_cnt <= pre_cnt + PRE_ONE;
        tick    <= 1'b0;
        wrap    <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      capt_valid <= '0;
      capt_ovf   <= '0;
      capt_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_CAPT; i++) begin
        if (capt_req[i]) begin
          if (!capt_valid[i] || capt_ack[i]) begin
            capt_q[i]     <= timestamp;
            capt_valid[i] <= 1'b1;
          end else begin
            capt_ovf[i] <= 1'b1;
          end
        end else if (capt_ack[i]) begin
          capt_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_timestamp_timer_mc.sv
// tb/tb_timestamp_timer_mc.sv - directed self-checking bench for timestamp_timer_mc
module tb_timestamp_timer_mc;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main instance: 16-bit timestamp, 4 channels
  logic        rst = 1'b1, enable = 1'b0, clear = 1'b0;
  logic [7:0]  div = '0;
  logic [15:0] ts;
  logic        tk, wr;
  logic [3:0]  ep;
  logic [3:0]  req = '0, ack = '0, cv, covf;
  logic [63:0] cts;

  // narrow instance for wrap/epoch/clear: 4-bit timestamp, 2-bit epoch
  logic        w_rst = 1'b1, w_en = 1'b0, w_clr = 1'b0;
  logic [3:0]  w_div = '0;
  logic [3:0]  w_ts;
  logic        w_tk, w_wr;
  logic [1:0]  w_ep;
  logic [1:0]  w_req = '0, w_ack = '0, w_cv, w_covf;
  logic [7:0]  w_cts;

  int checks = 0;
  int errors = 0;

  timestamp_timer_mc #(.TS_BITS(16), .PRESCALE_BITS(8), .EPOCH_BITS(4), .NUM_CAPT(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .prescale_div(div),
    .timestamp(ts), .tick(tk), .wrap(wr), .epoch(ep),
    .capt_req(req), .capt_ack(ack), .capt_valid(cv), .capt_ts(cts), .capt_ovf(covf)
  );

  timestamp_timer_mc #(.TS_BITS(4), .PRESCALE_BITS(4), .EPOCH_BITS(2), .NUM_CAPT(2)) dut_w (
    .clk(clk), .rst(w_rst), .enable(w_en), .clear(w_clr), .prescale_div(w_div),
    .timestamp(w_ts), .tick(w_tk), .wrap(w_wr), .epoch(w_ep),
    .capt_req(w_req), .capt_ack(w_ack), .capt_valid(w_cv), .capt_ts(w_cts), .capt_ovf(w_covf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({ts, tk, wr, ep, cv, covf, cts} !== '0) begin
      errors++;
      $display("FAIL reset_state got ts=%0d tick=%0b wrap=%0b epoch=%0d valid=%b ovf=%b cts=%h exp all 0",
               ts, tk, wr, ep, cv, covf, cts);
    end
    rst = 1'b0;
  endtask

  task automatic test_count();
    enable = 1'b1;
    div    = 8'd0;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (ts !== 16'(i) || tk !== 1'b1) begin
        errors++;
        $display("FAIL count_div0 got ts=%0d tick=%0b exp ts=%0d tick=1", ts, tk, i);
      end
    end
    rst = 1'b1;
    step();
    checks++;
    if (ts !== 16'd0 || tk !== 1'b0 || wr !== 1'b0 || ep !== 4'd0) begin
      errors++;
      $display("FAIL reset_midrun got ts=%0d tick=%0b wrap=%0b epoch=%0d exp 0", ts, tk, wr, ep);
    end
    rst = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_prescale();
    div    = 8'd3;
    enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (ts !== 16'(k / 4) || tk !== (k % 4 == 0)) begin
        errors++;
        $display("FAIL prescale3 step %0d got ts=%0d tick=%0b exp ts=%0d tick=%0b",
                 k, ts, tk, k / 4, (k % 4 == 0));
      end
    end
    step();
    step();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (ts !== 16'd2 || tk !== 1'b0) begin
        errors++;
        $display("FAIL freeze got ts=%0d tick=%0b exp ts=2 tick=0", ts, tk);
      end
    end
    enable = 1'b1;
    step();
    checks++;
    if (ts !== 16'd2 || tk !== 1'b0) begin
      errors++;
      $display("FAIL resume_wait got ts=%0d tick=%0b exp ts=2 tick=0", ts, tk);
    end
    step();
    checks++;
    if (ts !== 16'd3 || tk !== 1'b1) begin
      errors++;
      $display("FAIL resume_tick got ts=%0d tick=%0b exp ts=3 tick=1", ts, tk);
    end
    enable = 1'b0;
  endtask

  task automatic test_wrap();
    w_rst = 1'b1;
    step();
    w_rst = 1'b0;
    w_en  = 1'b1;
    w_div = 4'd0;
    for (int k = 0; k < 15; k++) step();
    checks++;
    if (w_ts !== 4'd15 || w_wr !== 1'b0 || w_ep !== 2'd0) begin
      errors++;
      $display("FAIL pre_wrap got ts=%0d wrap=%0b epoch=%0d exp ts=15 wrap=0 epoch=0", w_ts, w_wr, w_ep);
    end
    for (int n = 1; n <= 4; n++) begin
      step();
      checks++;
      if (w_ts !== 4'd0 || w_wr !== 1'b1 || w_tk !== 1'b1 || w_ep !== 2'((n > 3) ? 3 : n)) begin
        errors++;
        $display("FAIL wrap %0d got ts=%0d wrap=%0b tick=%0b epoch=%0d exp ts=0 wrap=1 tick=1 epoch=%0d",
                 n, w_ts, w_wr, w_tk, w_ep, (n > 3) ? 3 : n);
      end
      step();
      checks++;
      if (w_wr !== 1'b0) begin
        errors++;
        $display("FAIL wrap_pulse %0d got wrap=%0b exp 0", n, w_wr);
      end
      if (n < 4) for (int k = 0; k < 14; k++) step();
    end
  endtask

  task automatic test_clear();
    w_rst = 1'b1;
    step();
    w_rst = 1'b0;
    w_en  = 1'b1;
    for (int k = 0; k < 37; k++) step();
    w_req = 2'b01;
    step();
    w_req = 2'b00;
    checks++;
    if (w_cv !== 2'b01 || w_cts[3:0] !== 4'd5 || w_ts !== 4'd6 || w_ep !== 2'd2) begin
      errors++;
      $display("FAIL clr_setup got valid=%b cts0=%0d ts=%0d epoch=%0d exp valid=01 cts0=5 ts=6 epoch=2",
               w_cv, w_cts[3:0], w_ts, w_ep);
    end
    step();
    step();
    step();
    w_clr = 1'b1;
    w_req = 2'b10;
    step();
    w_clr = 1'b0;
    w_req = 2'b00;
    checks++;
    if (w_ts !== 4'd0 || w_ep !== 2'd0 || w_wr !== 1'b0 || w_tk !== 1'b0) begin
      errors++;
      $display("FAIL clear_counter got ts=%0d epoch=%0d wrap=%0b tick=%0b exp all 0", w_ts, w_ep, w_wr, w_tk);
    end
    checks++;
    if (w_cv !== 2'b11 || w_cts !== {4'd9, 4'd5} || w_covf !== 2'b00) begin
      errors++;
      $display("FAIL clear_capture got valid=%b cts=%h ovf=%b exp valid=11 cts=95 ovf=00", w_cv, w_cts, w_covf);
    end
    w_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    step();
    rst = 1'b0;
    div = 8'd0;
    enable = 1'b1;
    for (int k = 0; k < 7; k++) step();
    req = 4'b0001;
    ack = 4'b0000;
    step();
    checks++;
    if (cv[0] !== 1'b1 || cts[15:0] !== 16'd7 || covf[0] !== 1'b0) begin
      errors++;
      $display("FAIL cap_first got valid=%0b cts=%0d ovf=%0b exp 1 7 0", cv[0], cts[15:0], covf[0]);
    end
    step();
    checks++;
    if (cv[0] !== 1'b1 || cts[15:0] !== 16'd7 || covf[0] !== 1'b1) begin
      errors++;
      $display("FAIL cap_drop got valid=%0b cts=%0d ovf=%0b exp 1 7 1", cv[0], cts[15:0], covf[0]);
    end
    ack = 4'b0001;
    step();
    checks++;
    if (cv[0] !== 1'b1 || cts[15:0] !== 16'd9 || covf[0] !== 1'b1) begin
      errors++;
      $display("FAIL cap_b2b got valid=%0b cts=%0d ovf=%0b exp 1 9 1", cv[0], cts[15:0], covf[0]);
    end
    req = 4'b0000;
    step();
    ack = 4'b0000;
    checks++;
    if (cv[0] !== 1'b0 || cts[15:0] !== 16'd9 || covf[0] !== 1'b1) begin
      errors++;
      $display("FAIL cap_ack got valid=%0b cts=%0d ovf=%0b exp 0 9 1", cv[0], cts[15:0], covf[0]);
    end
  endtask

  task automatic test_multi_channel();
    for (int k = 0; k < 9; k++) step();
    checks++;
    if (ts !== 16'd20) begin
      errors++;
      $display("FAIL multi_setup got ts=%0d exp 20", ts);
    end
    req = 4'b1010;
    step();
    req = 4'b0000;
    checks++;
    if (cv !== 4'b1010 || cts[31:16] !== 16'd20 || cts[63:48] !== 16'd20) begin
      errors++;
      $display("FAIL multi_capture got valid=%b cts1=%0d cts3=%0d exp valid=1010 cts1=20 cts3=20",
               cv, cts[31:16], cts[63:48]);
    end
    checks++;
    if (cts[47:32] !== 16'd0 || covf !== 4'b0001) begin
      errors++;
      $display("FAIL multi_isolation got cts2=%0d ovf=%b exp cts2=0 ovf=0001", cts[47:32], covf);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_prescale();
    test_wrap();
    test_clear();
    test_back_to_back();
    test_multi_channel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
